sobel_gradient: RTL and testbench

- Consumes the 3x3 pixel window stream from the line-buffer controller: 72-bit window plus window valid.
- Computes Sobel Gx/Gy, an L1 gradient magnitude saturated to 8 bits, and a 2-bit quantised gradient direction for the downstream non-maximum-suppression stage.
- Fixed 3-stage pipeline with no backpressure.
- Tracks output position within a line and flags end-of-line.

---
 rtl/sobel_gradient_if.sv | 33 +++
 rtl/sobel_gradient.sv | 117 +++++++++++
 tb/tb_sobel_gradient.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_gradient_if.sv
// Window-in / gradient-out bundle for sobel_gradient.
// With SOBEL_THRESH_EN defined it also carries the i_thresh magnitude threshold.
interface sobel_gradient_if;
  logic [71:0] i_pixel_data;
  logic        i_pixel_data_valid;
`ifdef SOBEL_THRESH_EN
  logic [7:0]  i_thresh;
`endif
  logic [7:0]  o_mag;
  logic [1:0]  o_dir;
  logic        o_valid;
  logic        o_eol;

`ifdef SOBEL_THRESH_EN
  modport master (
    output i_pixel_data, i_pixel_data_valid, i_thresh,
    input  o_mag, o_dir, o_valid, o_eol
  );
  modport slave (
    input  i_pixel_data, i_pixel_data_valid, i_thresh,
    output o_mag, o_dir, o_valid, o_eol
  );
`else
  modport master (
    output i_pixel_data, i_pixel_data_valid,
    input  o_mag, o_dir, o_valid, o_eol
  );
  modport slave (
    input  i_pixel_data, i_pixel_data_valid,
    output o_mag, o_dir, o_valid, o_eol
  );
`endif
endinterface

// File: rtl/sobel_gradient.sv
// 3-stage Sobel gradient: Gx/Gy, saturated L1 magnitude, 4-sector direction, end-of-line flag.
// Optional SOBEL_THRESH_EN zeroes outputs whose magnitude is below i_thresh.
module sobel_gradient #(
  parameter int LINE_WIDTH = 512,
  parameter int MAG_SHIFT  = 0
) (
  input logic             i_clk,
  input logic             i_rst,
  sobel_gradient_if.slave bus
);

  localparam int              COL_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

  logic [10:0]        px [3][3];
  logic signed [10:0] gx_c, gy_c;
  logic signed [10:0] s1_gx, s1_gy;
  logic               s1_valid;

  logic [9:0]  ax_c, ay_c;
  logic [11:0] raw_c;
  logic [18:0] ay128, ax53, ax309;
  logic [1:0]  dir_c;
  logic [11:0] s2_raw;
  logic [1:0]  s2_dir;
  logic        s2_valid;

  logic [11:0]      shifted;
  logic [7:0]       sat_c;
  logic [7:0]       mag_c;
  logic [1:0]       dir_out_c;
  logic [COL_W-1:0] col;

  // Pixels are zero-extended to 11 bits so the modular difference is the signed result.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px[r][c] = {3'b000, bus.i_pixel_data[24*r + 8*c +: 8]};
      end
    end
    gx_c = $signed((px[0][2] + (px[1][2] << 1) + px[2][2])
                 - (px[0][0] + (px[1][0] << 1) + px[2][0]));
    gy_c = $signed((px[2][0] + (px[2][1] << 1) + px[2][2])
                 - (px[0][0] + (px[0][1] << 1) + px[0][2]));
  end

  // Sector edges at tan(22.5) ~ 53/128 and tan(67.5) ~ 309/128, compared exactly.
  always_comb begin
    ax_c  = s1_gx[10] ? 10'(-s1_gx) : s1_gx[9:0];
    ay_c  = s1_gy[10] ? 10'(-s1_gy) : s1_gy[9:0];
    raw_c = {2'b00, ax_c} + {2'b00, ay_c};
    ay128 = {2'b00, ay_c, 7'b0000000};
    ax53  = 19'(ax_c) * 19'd53;
    ax309 = 19'(ax_c) * 19'd309;
    if (ay128 <= ax53) begin
      dir_c = 2'd0;
    end else if (ay128 >= ax309) begin
      dir_c = 2'd2;
    end else if (s1_gx[10] == s1_gy[10]) begin
      dir_c = 2'd1;
    end else begin
      dir_c = 2'd3;
    end
  end

  always_comb begin
    shifted = s2_raw >> MAG_SHIFT;
    sat_c   = (shifted > 12'd255) ? 8'hFF : shifted[7:0];
`ifdef SOBEL_THRESH_EN
    if (sat_c < bus.i_thresh) begin
      mag_c     = 8'd0;
      dir_out_c = 2'd0;
    end else begin
      mag_c     = sat_c;
      dir_out_c = s2_dir;
    end
`else
    mag_c     = sat_c;
    dir_out_c = s2_dir;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (bus.i_pixel_data_valid) begin
      s1_gx <= gx_c;
      s1_gy <= gy_c;
    end
    if (s1_valid) begin
      s2_raw <= raw_c;
      s2_dir <= dir_c;
    end
  end

  // The column counter advances with each registered output, so idle gaps never move it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_eol   <= 1'b0;
      bus.o_mag   <= 8'd0;
      bus.o_dir   <= 2'd0;
      col         <= '0;
    end else begin
      s1_valid    <= bus.i_pixel_data_valid;
      s2_valid    <= s1_valid;
      bus.o_valid <= s2_valid;
      bus.o_eol   <= s2_valid && (col == COL_LAST);
      if (s2_valid) begin
        bus.o_mag <= mag_c;
        bus.o_dir <= dir_out_c;
        col       <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed-vector bench for sobel_gradient, run on a MAG_SHIFT=0 and a MAG_SHIFT=2 instance.
// The i_thresh scenario is compiled in only with SOBEL_THRESH_EN.
module tb_sobel_gradient;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sobel_gradient_if bus0 ();
  sobel_gradient_if bus2 ();

  sobel_gradient #(.LINE_WIDTH(512), .MAG_SHIFT(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  sobel_gradient #(.LINE_WIDTH(512), .MAG_SHIFT(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  typedef struct {
    logic [71:0] win;
    logic [7:0]  mag0;
    logic [7:0]  mag2;
    logic [1:0]  dir;
    string       name;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic logic [71:0] mk_win(input logic [7:0] a00, a01, a02, a10, a11, a12,
                                         a20, a21, a22);
    return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
  endfunction

  task automatic applyStimulus(input logic v, input logic [71:0] d);
    bus0.i_pixel_data_valid = v;
    bus0.i_pixel_data       = d;
    bus2.i_pixel_data_valid = v;
    bus2.i_pixel_data       = d;
  endtask

  // Expected magnitudes hand-derived: mag0 = min(|Gx|+|Gy|, 255), mag2 = min((|Gx|+|Gy|)>>2, 255).
  task automatic init_vectors();
    vecs[0]  = '{mk_win(100,100,100,100,100,100,100,100,100), 8'd0,   8'd0,   2'd0, "flat"};
    vecs[1]  = '{mk_win(0,0,255,0,0,255,0,0,255),             8'd255, 8'd255, 2'd0, "vert_edge"};
    vecs[2]  = '{mk_win(0,0,0,0,0,0,50,50,50),                8'd200, 8'd50,  2'd2, "horiz_edge"};
    vecs[3]  = '{mk_win(0,0,0,0,0,0,0,0,100),                 8'd200, 8'd50,  2'd1, "diag_w22"};
    vecs[4]  = '{mk_win(0,0,0,0,0,0,100,0,0),                 8'd200, 8'd50,  2'd3, "diag_w20"};
    vecs[5]  = '{mk_win(100,0,0,0,0,0,0,0,0),                 8'd200, 8'd50,  2'd1, "diag_w00"};
    vecs[6]  = '{mk_win(0,0,0,0,0,128,0,53,0),                8'd255, 8'd90,  2'd0, "edge53_eq"};
    vecs[7]  = '{mk_win(0,0,0,0,0,128,0,54,0),                8'd255, 8'd91,  2'd1, "edge53_above"};
    vecs[8]  = '{mk_win(0,0,0,0,0,128,54,255,54),             8'd255, 8'd218, 2'd2, "edge309_eq"};
    vecs[9]  = '{mk_win(0,0,0,0,0,128,0,0,0),                 8'd255, 8'd64,  2'd0, "raw256"};
    vecs[10] = '{mk_win(0,0,100,0,0,0,0,0,0),                 8'd200, 8'd50,  2'd3, "diag_w02"};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 72'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.o_valid, bus0.o_eol, bus0.o_mag, bus0.o_dir} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut0: got valid=%b eol=%b mag=%0d dir=%0d expected all 0",
               bus0.o_valid, bus0.o_eol, bus0.o_mag, bus0.o_dir);
    end
    checks++;
    if ({bus2.o_valid, bus2.o_eol, bus2.o_mag, bus2.o_dir} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut2: got valid=%b eol=%b mag=%0d dir=%0d expected all 0",
               bus2.o_valid, bus2.o_eol, bus2.o_mag, bus2.o_dir);
    end
    rst = 1'b0;
  endtask

  // One isolated window per vector: o_valid must be low after two edges and high after three.
  task automatic test_directions();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk) applyStimulus(1'b1, vecs[i].win);
      @(negedge clk) applyStimulus(1'b0, 72'd0);
      @(negedge clk);
      checks++;
      if (bus0.o_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL early_valid %s: got %b expected 0", vecs[i].name, bus0.o_valid);
      end
      @(negedge clk);
      checks++;
      if (bus0.o_valid !== 1'b1 || bus0.o_eol !== 1'b0 || bus0.o_mag !== vecs[i].mag0 ||
          bus0.o_dir !== vecs[i].dir) begin
        errors++;
        $display("[TB] FAIL dir_%s shift0: got v=%b eol=%b mag=%0d dir=%0d expected v=1 eol=0 mag=%0d dir=%0d",
                 vecs[i].name, bus0.o_valid, bus0.o_eol, bus0.o_mag, bus0.o_dir,
                 vecs[i].mag0, vecs[i].dir);
      end
      checks++;
      if (bus2.o_valid !== 1'b1 || bus2.o_mag !== vecs[i].mag2 || bus2.o_dir !== vecs[i].dir) begin
        errors++;
        $display("[TB] FAIL dir_%s shift2: got v=%b mag=%0d dir=%0d expected v=1 mag=%0d dir=%0d",
                 vecs[i].name, bus2.o_valid, bus2.o_mag, bus2.o_dir, vecs[i].mag2, vecs[i].dir);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NV + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        checks++;
        if (bus0.o_valid !== 1'b1 || bus0.o_mag !== vecs[k-3].mag0 || bus0.o_dir !== vecs[k-3].dir ||
            bus2.o_mag !== vecs[k-3].mag2) begin
          errors++;
          $display("[TB] FAIL b2b_%s: got v=%b mag0=%0d mag2=%0d dir=%0d expected v=1 mag0=%0d mag2=%0d dir=%0d",
                   vecs[k-3].name, bus0.o_valid, bus0.o_mag, bus2.o_mag, bus0.o_dir,
                   vecs[k-3].mag0, vecs[k-3].mag2, vecs[k-3].dir);
        end
      end
      if (k < NV) applyStimulus(1'b1, vecs[k].win);
      else        applyStimulus(1'b0, 72'd0);
    end
    @(negedge clk);
    checks++;
    if (bus0.o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_tail_valid: got %b expected 0", bus0.o_valid);
    end
  endtask

  // Reset lands on the edge that samples the third window, with two more already in the pipe.
  task automatic test_reset_midstream();
    @(negedge clk) applyStimulus(1'b1, vecs[2].win);
    @(negedge clk) applyStimulus(1'b1, vecs[3].win);
    @(negedge clk) begin
      applyStimulus(1'b1, vecs[4].win);
      rst = 1'b1;
    end
    @(negedge clk) begin
      rst = 1'b0;
      applyStimulus(1'b0, 72'd0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus0.o_valid !== 1'b0 || bus0.o_eol !== 1'b0 || bus2.o_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_flush cycle %0d: got v0=%b eol0=%b v2=%b expected 0 0 0",
                 i, bus0.o_valid, bus0.o_eol, bus2.o_valid);
      end
      @(negedge clk);
    end
  endtask

  // The counter starts from the mid-stream reset, so eol must land on outputs 512 and 1024.
  task automatic test_line_boundary();
    localparam int NWIN = 1030;
    int sent = 0, recv = 0, eols = 0, gap = 0, cyc = 0;
    logic exp_eol;
    while ((sent < NWIN || recv < NWIN) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus0.o_valid === 1'b1) begin
        recv++;
        exp_eol = (recv % 512 == 0);
        if (bus0.o_eol === 1'b1) eols++;
        checks++;
        if (bus0.o_eol !== exp_eol || bus2.o_eol !== exp_eol) begin
          errors++;
          $display("[TB] FAIL eol_out%0d: got eol0=%b eol2=%b expected %b",
                   recv, bus0.o_eol, bus2.o_eol, exp_eol);
        end
      end else if (bus0.o_eol !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL eol_without_valid at cycle %0d: got %b expected 0", cyc, bus0.o_eol);
      end
      if (sent < NWIN && gap == 0) begin
        applyStimulus(1'b1, vecs[sent % NV].win);
        sent++;
        gap = $urandom_range(3, 1);
      end else begin
        applyStimulus(1'b0, 72'd0);
        if (gap > 0) gap--;
      end
    end
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("[TB] FAIL line_timeout: got %0d outputs expected %0d", recv, NWIN);
    end
    repeat (5) begin
      @(negedge clk);
      if (bus0.o_valid === 1'b1) recv++;
    end
    checks++;
    if (recv != sent) begin
      errors++;
      $display("[TB] FAIL out_count: got %0d expected %0d", recv, sent);
    end
    checks++;
    if (eols != 2) begin
      errors++;
      $display("[TB] FAIL eol_count: got %0d expected 2", eols);
    end
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    bus0.i_thresh = 8'd201;
    bus2.i_thresh = 8'd201;
    @(negedge clk) applyStimulus(1'b1, vecs[2].win);
    @(negedge clk) applyStimulus(1'b0, 72'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.o_valid !== 1'b1 || bus0.o_mag !== 8'd0 || bus0.o_dir !== 2'd0) begin
      errors++;
      $display("[TB] FAIL thresh201: got v=%b mag=%0d dir=%0d expected v=1 mag=0 dir=0",
               bus0.o_valid, bus0.o_mag, bus0.o_dir);
    end
    bus0.i_thresh = 8'd200;
    bus2.i_thresh = 8'd200;
    @(negedge clk) applyStimulus(1'b1, vecs[2].win);
    @(negedge clk) applyStimulus(1'b0, 72'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.o_valid !== 1'b1 || bus0.o_mag !== 8'd200 || bus0.o_dir !== 2'd2 ||
        bus2.o_mag !== 8'd0 || bus2.o_dir !== 2'd0) begin
      errors++;
      $display("[TB] FAIL thresh200: got v=%b mag0=%0d dir0=%0d mag2=%0d dir2=%0d expected v=1 200 2 0 0",
               bus0.o_valid, bus0.o_mag, bus0.o_dir, bus2.o_mag, bus2.o_dir);
    end
    bus0.i_thresh = 8'd0;
    bus2.i_thresh = 8'd0;
  endtask
`endif

  initial begin
`ifdef SOBEL_THRESH_EN
    bus0.i_thresh = 8'd0;
    bus2.i_thresh = 8'd0;
`endif
    init_vectors();
    test_reset();
    test_directions();
    test_back_to_back();
    test_reset_midstream();
    test_line_boundary();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
